// File: rtl/conv1_pkg.sv
// ============================================================================
//  Module      : conv1_pkg
//  Description : Shared constants and types for the conv1 weight-load path.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv1_pkg;
    localparam int DATA_W     = 16;
    localparam int K_SIZE     = 5;
    localparam int NWORDS     = K_SIZE * K_SIZE;
    localparam int KERN1_BASE = 25;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        DRAIN  = 2'd2,
        LOADED = 2'd3
    } state_e;

    typedef logic signed [DATA_W-1:0] weight_t;
endpackage

`default_nettype wire

// File: rtl/conv1_kernel_loader_if.sv
// ============================================================================
//  Module      : conv1_kernel_loader_if
//  Description : Load request, ROM read streams and flat kernel outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface conv1_kernel_loader_if #(
    parameter int DATA_W = conv1_pkg::DATA_W,
    parameter int NWORDS = conv1_pkg::NWORDS
);
    logic                     start;
    logic                     cnt_en;
    logic [DATA_W-1:0]        rdata0;
    logic [DATA_W-1:0]        rdata1;
    logic [NWORDS*DATA_W-1:0] k0_flat;
    logic [NWORDS*DATA_W-1:0] k1_flat;
    logic                     busy;
    logic                     kvalid;

    modport master (
        output start, rdata0, rdata1,
        input  cnt_en, k0_flat, k1_flat, busy, kvalid
    );

    modport slave (
        input  start, rdata0, rdata1,
        output cnt_en, k0_flat, k1_flat, busy, kvalid
    );
endinterface

`default_nettype wire

// File: rtl/kernel_bank.sv
// ============================================================================
//  Module      : kernel_bank
//  Description : NWORDS x DATA_W register file with async clear, flat output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module kernel_bank #(
    parameter int DATA_W = 16,
    parameter int NWORDS = 25,
    parameter int IDX_W  = $clog2(NWORDS + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [IDX_W-1:0]         wr_idx,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [NWORDS*DATA_W-1:0] flat
);
    logic [DATA_W-1:0] r_mem [NWORDS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NWORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en && (wr_idx < IDX_W'(NWORDS))) begin
            r_mem[wr_idx] <= wr_data;
        end
    end

    for (genvar g = 0; g < NWORDS; g++) begin : g_flat
        assign flat[g*DATA_W +: DATA_W] = r_mem[g];
    end
endmodule

`default_nettype wire

// File: rtl/conv1_kernel_loader.sv
// ============================================================================
//  Module      : conv1_kernel_loader
//  Description : Drives the weight-address counter and captures both ROM
//                read streams into two static kernel banks, once per reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv1_kernel_loader #(
    parameter int DATA_W  = conv1_pkg::DATA_W,
    parameter int K_SIZE  = conv1_pkg::K_SIZE,
    parameter int ROM_LAT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    conv1_kernel_loader_if.slave bus
);
    import conv1_pkg::*;

    localparam int NWORDS = K_SIZE * K_SIZE;
    localparam int CW     = $clog2(NWORDS + 1);
    localparam int DW     = $clog2(ROM_LAT + 1);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_FETCH  = FETCH;
    localparam logic [1:0] ST_DRAIN  = DRAIN;
    localparam logic [1:0] ST_LOADED = LOADED;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_issue_cnt;
    logic [DW-1:0]      r_drain_cnt;
    logic [CW-1:0]      r_cap_cnt;
    logic [ROM_LAT-1:0] r_vpipe;
    logic               w_fetch;
    logic               w_cap;

    assign w_fetch = (r_state == ST_FETCH);
    assign w_cap   = r_vpipe[ROM_LAT-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_issue_cnt <= '0;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state     <= ST_FETCH;
                        r_issue_cnt <= '0;
                    end
                end
                ST_FETCH: begin
                    r_issue_cnt <= r_issue_cnt + 1'b1;
                    if (r_issue_cnt == CW'(NWORDS - 1)) begin
                        r_state     <= ST_DRAIN;
                        r_drain_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    r_drain_cnt <= r_drain_cnt + 1'b1;
                    if (r_drain_cnt == DW'(ROM_LAT - 1)) begin
                        r_state <= ST_LOADED;
                    end
                end
                default: r_state <= ST_LOADED;
            endcase
        end
    end

    // Valid pipe mirrors the ROM read latency so capture lines up with rdata.
    if (ROM_LAT == 1) begin : g_pipe1
        always_ff @(posedge clk or posedge reset) begin
            if (reset) r_vpipe <= '0;
            else       r_vpipe <= w_fetch;
        end
    end else begin : g_pipen
        always_ff @(posedge clk or posedge reset) begin
            if (reset) r_vpipe <= '0;
            else       r_vpipe <= {r_vpipe[ROM_LAT-2:0], w_fetch};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)      r_cap_cnt <= '0;
        else if (w_cap) r_cap_cnt <= r_cap_cnt + 1'b1;
    end

    logic [NWORDS*DATA_W-1:0] w_k0_flat;
    logic [NWORDS*DATA_W-1:0] w_k1_flat;

    kernel_bank #(.DATA_W(DATA_W), .NWORDS(NWORDS), .IDX_W(CW)) u_bank0 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_cap),
        .wr_idx  (r_cap_cnt),
        .wr_data (bus.rdata0),
        .flat    (w_k0_flat)
    );

    kernel_bank #(.DATA_W(DATA_W), .NWORDS(NWORDS), .IDX_W(CW)) u_bank1 (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_cap),
        .wr_idx  (r_cap_cnt),
        .wr_data (bus.rdata1),
        .flat    (w_k1_flat)
    );

    assign bus.cnt_en  = w_fetch;
    assign bus.busy    = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
    assign bus.kvalid  = (r_state == ST_LOADED);
    assign bus.k0_flat = w_k0_flat;
    assign bus.k1_flat = w_k1_flat;

    a_full_on_loaded : assert property (@(posedge clk) disable iff (reset)
        (r_state == ST_LOADED) |-> (r_cap_cnt == CW'(NWORDS)));

    a_cap_window : assert property (@(posedge clk) disable iff (reset)
        w_cap |-> (((r_state == ST_FETCH) || (r_state == ST_DRAIN)) && (r_cap_cnt < CW'(NWORDS))));
endmodule

`default_nettype wire

// File: tb/tb_conv1_kernel_loader.sv
// ============================================================================
//  Module      : tb_conv1_kernel_loader
//  Description : Drives ROM_LAT=1 and ROM_LAT=2 loaders side by side against a ROM model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv1_kernel_loader;
    import conv1_pkg::*;

    localparam int FW = NWORDS * DATA_W;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    bit   rnd   = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    weight_t    rom [0:63];
    logic [5:0] a1, a2;
    weight_t    s2_0, s2_1;

    always #5 clk = ~clk;

    conv1_kernel_loader_if #(.DATA_W(DATA_W), .NWORDS(NWORDS)) bus1 ();
    conv1_kernel_loader_if #(.DATA_W(DATA_W), .NWORDS(NWORDS)) bus2 ();

    assign bus1.start = start;
    assign bus2.start = start;

    conv1_kernel_loader #(.DATA_W(DATA_W), .K_SIZE(K_SIZE), .ROM_LAT(1)) dut1 (
        .clk (clk), .reset (reset), .bus (bus1));
    conv1_kernel_loader #(.DATA_W(DATA_W), .K_SIZE(K_SIZE), .ROM_LAT(2)) dut2 (
        .clk (clk), .reset (reset), .bus (bus2));

    // Address counters share the loader reset; ROM ports read addr and addr+KERN1_BASE.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            a1 <= '0;
            a2 <= '0;
        end else begin
            if (bus1.cnt_en) a1 <= a1 + 6'd1;
            if (bus2.cnt_en) a2 <= a2 + 6'd1;
        end
    end

    always @(posedge clk) begin
        if (rnd) begin
            bus1.rdata0 <= DATA_W'($urandom);
            bus1.rdata1 <= DATA_W'($urandom);
            bus2.rdata0 <= DATA_W'($urandom);
            bus2.rdata1 <= DATA_W'($urandom);
        end else begin
            bus1.rdata0 <= rom[a1];
            bus1.rdata1 <= rom[a1 + KERN1_BASE];
            s2_0        <= rom[a2];
            s2_1        <= rom[a2 + KERN1_BASE];
            bus2.rdata0 <= s2_0;
            bus2.rdata1 <= s2_1;
        end
    end

    task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Kernel image expected from the ROM contents: the first n slots filled, the rest zero.
    function automatic logic [FW-1:0] exp_flat(input int base, input int n);
        logic [FW-1:0] f = '0;
        for (int i = 0; i < NWORDS; i++)
            if (i < n) f[i*DATA_W +: DATA_W] = rom[base + i];
        return f;
    endfunction

    task automatic rom_fill(input bit random_data);
        for (int a = 0; a < 64; a++)
            rom[a] = random_data ? weight_t'($urandom) : weight_t'(a);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic run_load(input bit hold, input string tag);
        int en1 = 0, en2 = 0, fe1 = 0, le1 = 0;
        int kv1 = 0, kv2 = 0, kf1 = 0, kf2 = 0, bz1 = 0, bz2 = 0;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (bus1.cnt_en) begin
                en1++;
                if (fe1 == 0) fe1 = c;
                le1 = c;
            end
            if (bus2.cnt_en) en2++;
            if (bus1.kvalid) begin kv1++; if (kf1 == 0) kf1 = c; end
            if (bus2.kvalid) begin kv2++; if (kf2 == 0) kf2 = c; end
            if (bus1.busy) bz1++;
            if (bus2.busy) bz2++;
            tick();
        end
        start = 1'b0;
        chk({tag, ".en_cycles1"}, FW'(en1), FW'(NWORDS));
        chk({tag, ".en_first1"},  FW'(fe1), FW'(1));
        chk({tag, ".en_last1"},   FW'(le1), FW'(NWORDS));
        chk({tag, ".en_cycles2"}, FW'(en2), FW'(NWORDS));
        chk({tag, ".kv_first1"},  FW'(kf1), FW'(NWORDS + 1 + 1));
        chk({tag, ".kv_first2"},  FW'(kf2), FW'(NWORDS + 2 + 1));
        chk({tag, ".kv_cycles1"}, FW'(kv1), FW'(60 - (NWORDS + 2) + 1));
        chk({tag, ".kv_cycles2"}, FW'(kv2), FW'(60 - (NWORDS + 3) + 1));
        chk({tag, ".busy1"},      FW'(bz1), FW'(NWORDS + 1));
        chk({tag, ".busy2"},      FW'(bz2), FW'(NWORDS + 2));
        chk({tag, ".k0_lat1"}, bus1.k0_flat, exp_flat(0, NWORDS));
        chk({tag, ".k1_lat1"}, bus1.k1_flat, exp_flat(KERN1_BASE, NWORDS));
        chk({tag, ".k0_lat2"}, bus2.k0_flat, exp_flat(0, NWORDS));
        chk({tag, ".k1_lat2"}, bus2.k1_flat, exp_flat(KERN1_BASE, NWORDS));
    endtask

    initial begin
        int n_act, n_chg;
        rom_fill(1'b0);

        // Reset state
        reset = 1'b1;
        repeat (3) tick();
        chk("rst.ctl", FW'({bus1.cnt_en, bus1.busy, bus1.kvalid,
                            bus2.cnt_en, bus2.busy, bus2.kvalid}), '0);
        chk("rst.k0_lat1", bus1.k0_flat, '0);
        chk("rst.k1_lat1", bus1.k1_flat, '0);
        chk("rst.k_lat2", bus2.k0_flat | bus2.k1_flat, '0);
        reset = 1'b0;
        n_act = 0;
        repeat (5) begin
            tick();
            if (bus1.cnt_en || bus1.busy || bus1.kvalid || bus2.cnt_en || bus2.busy) n_act++;
        end
        chk("idle.no_activity", FW'(n_act), '0);

        // Nominal load, rdata = address
        run_load(1'b0, "nom");

        // LOADED: toggling start and random rdata must not disturb anything
        rnd   = 1'b1;
        n_act = 0;
        n_chg = 0;
        for (int c = 0; c < 30; c++) begin
            start = 1'($urandom_range(0, 1));
            tick();
            if (bus1.cnt_en || bus1.busy || bus2.cnt_en || bus2.busy) n_act++;
            if (bus1.k0_flat !== exp_flat(0, NWORDS) || bus1.k1_flat !== exp_flat(KERN1_BASE, NWORDS) ||
                bus2.k0_flat !== exp_flat(0, NWORDS) || bus2.k1_flat !== exp_flat(KERN1_BASE, NWORDS))
                n_chg++;
        end
        start = 1'b0;
        rnd   = 1'b0;
        chk("loaded.activity", FW'(n_act), '0);
        chk("loaded.bank_changes", FW'(n_chg), '0);
        chk("loaded.kvalid", FW'({bus1.kvalid, bus2.kvalid}), FW'(2'b11));

        // Start held high across the whole load, random weights
        do_reset();
        rom_fill(1'b1);
        run_load(1'b1, "hold");

        // Reset in FETCH cycle 10 with partially filled banks
        do_reset();
        rom_fill(1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        chk("mid.partial_k0_lat1", bus1.k0_flat, exp_flat(0, 10 - 2 - 1 + 1));
        chk("mid.partial_k1_lat2", bus2.k1_flat, exp_flat(KERN1_BASE, 10 - 2 - 2 + 1));
        reset = 1'b1;
        #1;
        chk("mid.ctl_cleared", FW'({bus1.cnt_en, bus1.busy, bus1.kvalid,
                                    bus2.cnt_en, bus2.busy, bus2.kvalid}), '0);
        chk("mid.banks_cleared", bus1.k0_flat | bus1.k1_flat | bus2.k0_flat | bus2.k1_flat, '0);
        tick();
        tick();
        reset = 1'b0;
        n_act = 0;
        repeat (4) begin
            tick();
            if (bus1.cnt_en || bus1.kvalid || bus2.cnt_en || bus2.kvalid) n_act++;
        end
        chk("mid.no_autostart", FW'(n_act), '0);
        rom_fill(1'b0);
        run_load(1'b0, "reload");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
